// File: rtl/sub_bytes_iter.sv
`default_nettype none
// ============================================================================
//  Module   : sub_bytes_iter
//  Brief    : Iterative AES SubBytes / InvSubBytes over a 128-bit state.
//             LANES S-box lanes per clock, BEATS = 16/LANES cycles per block,
//             valid/ready handshakes on both sides.
//  Revision : 1.0 - initial release
// ============================================================================
module sub_bytes_iter #(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    input  logic         in_inv,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);

    localparam int BEATS  = 16 / LANES;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
        $error("sub_bytes_iter: LANES must be 1, 2, 4, 8 or 16");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254; maps 0x00 to 0x00 naturally.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] t;
        t = gf_mul(x, x);   // x^2
        t = gf_mul(t, x);   // x^3
        t = gf_mul(t, t);   // x^6
        t = gf_mul(t, x);   // x^7
        t = gf_mul(t, t);   // x^14
        t = gf_mul(t, x);   // x^15
        t = gf_mul(t, t);   // x^30
        t = gf_mul(t, x);   // x^31
        t = gf_mul(t, t);   // x^62
        t = gf_mul(t, x);   // x^63
        t = gf_mul(t, t);   // x^126
        t = gf_mul(t, x);   // x^127
        t = gf_mul(t, t);   // x^254
        return t;
    endfunction

    // Forward affine: b ^ rotl1 ^ rotl2 ^ rotl3 ^ rotl4 ^ 0x63.
    function automatic logic [7:0] fwd_affine(input logic [7:0] b);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    // Inverse affine: rotl1 ^ rotl3 ^ rotl6 ^ 0x05.
    function automatic logic [7:0] inv_affine(input logic [7:0] b);
        return {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
    endfunction

    state_t              fsm_q, fsm_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic [127:0]        data_q, data_d;
    logic                mode_q, mode_d;
    logic [127:0]        result_q, result_d;
    logic                in_ready_q, in_ready_d;
    logic                out_valid_q, out_valid_d;
    logic                busy_q, busy_d;
    logic [127:0]        merged_result;

    // Substitute the LANES bytes selected by the current beat into the result image.
    always_comb begin
        merged_result = result_q;
        for (int j = 0; j < LANES; j++) begin
            logic [3:0] idx;
            logic [7:0] src;
            idx = 4'(32'(beat_q) * LANES + j);
            src = data_q[{idx, 3'b000} +: 8];
            merged_result[{idx, 3'b000} +: 8] = mode_q ? gf_inv(inv_affine(src))
                                                       : fwd_affine(gf_inv(src));
        end
    end

    // Next-state and registered-output computation for the IDLE/BUSY/DONE control.
    always_comb begin
        fsm_d       = fsm_q;
        beat_d      = beat_q;
        data_d      = data_q;
        mode_d      = mode_q;
        result_d    = result_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        case (fsm_q)
            ST_IDLE: begin
                if (in_valid) begin
                    data_d     = in_state;
                    mode_d     = in_inv;
                    beat_d     = '0;
                    fsm_d      = ST_BUSY;
                    in_ready_d = 1'b0;
                    busy_d     = 1'b1;
                end
            end
            ST_BUSY: begin
                result_d = merged_result;
                if (beat_q == BEAT_W'(BEATS - 1)) begin
                    beat_d      = '0;
                    fsm_d       = ST_DONE;
                    out_valid_d = 1'b1;
                end else begin
                    beat_d = beat_q + 1'b1;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    fsm_d       = ST_IDLE;
                    out_valid_d = 1'b0;
                    busy_d      = 1'b0;
                    in_ready_d  = 1'b1;
                end
            end
            default: begin
                fsm_d       = ST_IDLE;
                beat_d      = '0;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
                busy_d      = 1'b0;
            end
        endcase
    end

    // State registers; reset abandons any block in flight immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fsm_q       <= ST_IDLE;
            beat_q      <= '0;
            data_q      <= '0;
            mode_q      <= 1'b0;
            result_q    <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            beat_q      <= beat_d;
            data_q      <= data_d;
            mode_q      <= mode_d;
            result_q    <= result_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign out_state = result_q;

endmodule
`default_nettype wire

// File: tb/tb_sub_bytes_iter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sub_bytes_iter
//  Brief    : Self-checking bench for sub_bytes_iter at LANES = 1,2,4,8,16
//             against a table-based S-box model built from GF(2^8) arithmetic.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sub_bytes_iter;

    logic         clk = 1'b0;
    logic         reset;
    logic [4:0]   in_valid, in_inv, out_ready;
    logic [4:0]   in_ready, out_valid, busy;
    logic [127:0] in_state  [5];
    logic [127:0] out_state [5];

    int checks = 0;
    int errors = 0;

    logic [7:0] sbox_tab  [256];
    logic [7:0] isbox_tab [256];

    localparam logic [127:0] VEC = 128'h08_48_f8_e9_2a_8d_c6_9a_2b_e2_f4_a0_be_e3_3d_19;
    localparam logic [127:0] EXP = 128'h30_52_41_1e_e5_5d_b4_b8_f1_98_bf_e0_ae_11_27_d4;

    always #5 clk = ~clk;

    // Instance k uses LANES = 2^k.
    for (genvar k = 0; k < 5; k++) begin : g_dut
        sub_bytes_iter #(.LANES(1 << k)) u_dut (
            .clk       (clk),
            .reset     (reset),
            .in_valid  (in_valid[k]),
            .in_ready  (in_ready[k]),
            .in_state  (in_state[k]),
            .in_inv    (in_inv[k]),
            .out_valid (out_valid[k]),
            .out_ready (out_ready[k]),
            .out_state (out_state[k]),
            .busy      (busy[k])
        );
    end

    // Polynomial product then reduction by 0x11B.
    function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
        logic [14:0] p;
        p = '0;
        for (int i = 0; i < 8; i++)
            if (b[i]) p = p ^ (15'(a) << i);
        for (int i = 14; i >= 8; i--)
            if (p[i]) p = p ^ (15'h11b << (i - 8));
        return p[7:0];
    endfunction

    task automatic build_tables();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv;
            logic [7:0] s;
            logic [7:0] c;
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (ref_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            c = 8'h63;
            for (int i = 0; i < 8; i++)
                s[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8] ^ inv[(i + 6) % 8] ^ inv[(i + 7) % 8] ^ c[i];
            sbox_tab[x]   = s;
            isbox_tab[s]  = 8'(x);
        end
    endtask

    function automatic logic [127:0] model_sub(input logic [127:0] st, input logic inv);
        logic [127:0] r;
        for (int i = 0; i < 16; i++)
            r[8*i +: 8] = inv ? isbox_tab[st[8*i +: 8]] : sbox_tab[st[8*i +: 8]];
        return r;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Offer one block on instance k and wait (bounded) for its result.
    task automatic start_block(input int k, input logic [127:0] st, input logic inv,
                               output int lat, output bit busy_ok);
        int w;
        w = 0;
        while (!in_ready[k] && w < 64) begin @(negedge clk); w++; end
        in_valid[k]  = 1'b1;
        in_state[k]  = st;
        in_inv[k]    = inv;
        out_ready[k] = 1'b0;
        @(negedge clk);
        in_valid[k]  = 1'b0;
        in_state[k]  = rand128();
        in_inv[k]    = ~inv;
        busy_ok      = busy[k] && !in_ready[k];
        lat = 0;
        while (!out_valid[k] && lat < 64) begin
            @(negedge clk);
            lat++;
            busy_ok = busy_ok && busy[k] && !in_ready[k];
        end
    endtask

    task automatic finish_block(input int k, output bit idle_ok);
        out_ready[k] = 1'b1;
        @(negedge clk);
        out_ready[k] = 1'b0;
        idle_ok = in_ready[k] && !out_valid[k] && !busy[k];
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        in_valid  = '0;
        in_inv    = '0;
        out_ready = '0;
        for (int k = 0; k < 5; k++) in_state[k] = '0;
        #12;
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (in_ready[k] !== 1'b1 || out_valid[k] !== 1'b0 || busy[k] !== 1'b0 || out_state[k] !== 128'h0) begin
                errors++;
                $display("FAIL reset[%0d]: in_ready=%b out_valid=%b busy=%b out_state=%h, required 1 0 0 0",
                         k, in_ready[k], out_valid[k], busy[k], out_state[k]);
            end
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_known_vector();
        int lat; bit bok; bit iok;
        start_block(2, VEC, 1'b0, lat, bok);
        checks++;
        if (lat !== 4) begin errors++; $display("FAIL fwd_latency: got %0d, required 4", lat); end
        checks++;
        if (out_state[2] !== EXP) begin errors++; $display("FAIL fwd_vector: got %h, required %h", out_state[2], EXP); end
        checks++;
        if (!bok) begin errors++; $display("FAIL fwd_busy: busy/in_ready wrong while processing, got 0 required 1"); end
        finish_block(2, iok);
        checks++;
        if (!iok) begin errors++; $display("FAIL fwd_handshake: idle state after handshake got 0, required 1"); end
    endtask

    task automatic test_inverse();
        int lat; bit bok; bit iok;
        logic [127:0] st;
        start_block(2, EXP, 1'b1, lat, bok);
        checks++;
        if (out_state[2] !== VEC) begin errors++; $display("FAIL inv_vector: got %h, required %h", out_state[2], VEC); end
        finish_block(2, iok);
        st = rand128();
        st[15:0] = 16'hff_00;
        start_block(2, st, 1'b0, lat, bok);
        checks++;
        if (out_state[2][15:0] !== 16'h16_63 || out_state[2] !== model_sub(st, 1'b0)) begin
            errors++; $display("FAIL fwd_boundary: got %h, required %h", out_state[2], model_sub(st, 1'b0));
        end
        finish_block(2, iok);
        st = rand128();
        st[15:0] = 16'h16_63;
        start_block(2, st, 1'b1, lat, bok);
        checks++;
        if (out_state[2][15:0] !== 16'hff_00 || out_state[2] !== model_sub(st, 1'b1)) begin
            errors++; $display("FAIL inv_boundary: got %h, required %h", out_state[2], model_sub(st, 1'b1));
        end
        finish_block(2, iok);
    endtask

    task automatic test_lanes();
        int lat; bit bok; bit iok;
        for (int k = 0; k < 5; k++) begin
            if (k == 2) continue;
            start_block(k, VEC, 1'b0, lat, bok);
            checks++;
            if (lat !== (16 >> k) || out_state[k] !== EXP || !bok) begin
                errors++;
                $display("FAIL lanes_%0d: latency %0d data %h busy_ok %0b, required latency %0d data %h busy_ok 1",
                         1 << k, lat, out_state[k], bok, 16 >> k, EXP);
            end
            finish_block(k, iok);
            checks++;
            if (!iok) begin errors++; $display("FAIL lanes_%0d_handshake: got 0, required 1", 1 << k); end
        end
    endtask

    task automatic test_random();
        int lat; bit bok; bit iok;
        logic [127:0] st;
        logic inv;
        for (int k = 0; k < 5; k++) begin
            for (int n = 0; n < 4; n++) begin
                st  = rand128();
                inv = 1'(n);
                start_block(k, st, inv, lat, bok);
                checks++;
                if (lat !== (16 >> k) || out_state[k] !== model_sub(st, inv)) begin
                    errors++;
                    $display("FAIL random_l%0d_%0d: latency %0d data %h, required latency %0d data %h",
                             1 << k, n, lat, out_state[k], 16 >> k, model_sub(st, inv));
                end
                finish_block(k, iok);
            end
        end
    endtask

    task automatic test_backpressure();
        int lat; bit bok; bit iok;
        logic [127:0] st;
        logic [127:0] held;
        logic inv;
        st  = rand128();
        inv = 1'($urandom);
        start_block(2, st, inv, lat, bok);
        held = model_sub(st, inv);
        for (int c = 0; c < 10; c++) begin
            in_valid[2] = 1'($urandom);
            in_state[2] = rand128();
            in_inv[2]   = 1'($urandom);
            @(negedge clk);
            checks++;
            if (out_state[2] !== held || in_ready[2] !== 1'b0 || out_valid[2] !== 1'b1) begin
                errors++;
                $display("FAIL hold_%0d: out_state %h in_ready %b out_valid %b, required %h 0 1",
                         c, out_state[2], in_ready[2], out_valid[2], held);
            end
        end
        in_valid[2] = 1'b0;
        finish_block(2, iok);
        checks++;
        if (!iok) begin errors++; $display("FAIL hold_release: idle after release got 0, required 1"); end
    endtask

    task automatic test_reset_mid();
        int lat; bit bok; bit iok;
        in_valid[2] = 1'b1;
        in_state[2] = rand128();
        in_inv[2]   = 1'b0;
        @(negedge clk);            // accepting edge passed
        in_valid[2] = 1'b0;
        @(negedge clk);            // beat 0 written
        @(negedge clk);            // now at beat 2
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (out_valid[2] !== 1'b0 || in_ready[2] !== 1'b1 || busy[2] !== 1'b0 || out_state[2] !== 128'h0) begin
            errors++;
            $display("FAIL reset_mid: out_valid %b in_ready %b busy %b out_state %h, required 0 1 0 0",
                     out_valid[2], in_ready[2], busy[2], out_state[2]);
        end
        @(negedge clk);
        reset = 1'b0;
        start_block(2, {16{8'h53}}, 1'b0, lat, bok);
        checks++;
        if (out_state[2] !== {16{8'hed}} || lat !== 4) begin
            errors++;
            $display("FAIL after_reset: got %h latency %0d, required %h latency 4", out_state[2], lat, {16{8'hed}});
        end
        finish_block(2, iok);
    endtask

    task automatic test_back_to_back();
        logic [127:0] exp_q[$];
        logic [127:0] e;
        int  last_hs;
        int  delivered;
        bit  accepted;
        logic mode;
        last_hs      = -1;
        delivered    = 0;
        mode         = 1'b0;
        in_valid[2]  = 1'b1;
        in_state[2]  = rand128();
        in_inv[2]    = mode;
        out_ready[2] = 1'b1;
        for (int cyc = 0; cyc < 80; cyc++) begin
            accepted = 1'b0;
            if (in_ready[2] && in_valid[2]) begin
                exp_q.push_back(model_sub(in_state[2], in_inv[2]));
                accepted = 1'b1;
                if (last_hs >= 0) begin
                    checks++;
                    if (cyc !== last_hs + 1) begin
                        errors++; $display("FAIL b2b_accept_gap: accept at %0d, required %0d", cyc, last_hs + 1);
                    end
                end
            end
            if (out_valid[2] && out_ready[2]) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 128'hx;
                checks++;
                if (out_state[2] !== e) begin
                    errors++; $display("FAIL b2b_data_%0d: got %h, required %h", delivered, out_state[2], e);
                end
                last_hs = cyc;
                delivered++;
            end
            @(negedge clk);
            if (accepted) begin
                mode        = ~mode;
                in_state[2] = rand128();
                in_inv[2]   = mode;
            end
        end
        in_valid[2] = 1'b0;
        repeat (12) @(negedge clk);
        out_ready[2] = 1'b0;
        checks++;
        if (delivered < 10 || in_ready[2] !== 1'b1) begin
            errors++; $display("FAIL b2b_count: delivered %0d in_ready %b, required >=10 and 1", delivered, in_ready[2]);
        end
    endtask

    initial begin
        build_tables();
        test_reset();
        test_known_vector();
        test_inverse();
        test_lanes();
        test_random();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sub_bytes_iter.md
Name: sub_bytes_iter

Overview:
- Sequential, parametrised successor to the combinational 128-bit SubBytes stage.
- Applies the AES S-box (forward, SubBytes) or inverse S-box (InvSubBytes) to a 128-bit state, LANES bytes per clock, so area trades against latency.
- Sits between AddRoundKey and ShiftRows in the iterative encrypt/decrypt datapaths.
- Uses valid/ready handshakes on both sides.

Parameters:
- LANES, 4, S-box lanes used per cycle. Legal values: 1, 2, 4, 8, 16. Any other value is a compile-time error.
- BEATS, 16/LANES, derived (localparam), number of processing cycles per block.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream holds a valid state/mode.
- in_ready  out  1  block can accept a new state.
- in_state  in  128  input state. Byte i = in_state[8i+7:8i].
- in_inv  in  1  0 = forward S-box, 1 = inverse S-box. Sampled with in_state.
- out_valid  out  1  out_state holds a finished result.
- out_ready  in  1  downstream accepts the result.
- out_state  out  128  substituted state. Byte i = S(byte i) or S^-1(byte i).
- busy  out  1  high in BUSY or DONE.

Behaviour:
- The design is clocked by clk only. On reset assertion, without waiting for a clock edge:
  - FSM goes to IDLE; beat counter = 0.
  - in_ready = 1, out_valid = 0, busy = 0.
  - out_state = 0; internal state and mode registers = 0.
- The FSM has three states:
  - IDLE: in_ready = 1. If in_valid is high at an edge, capture in_state, in_inv and beat = 0, then go to BUSY.
  - BUSY: in_ready = 0. Each edge, lane j (j = 0..LANES-1) writes byte (beat*LANES + j) of the result register. beat increments. At the edge where beat = BEATS-1, go to DONE and clear beat.
  - DONE: out_valid = 1; out_state is stable. If out_ready is high at an edge, go to IDLE. in_ready stays 0 in DONE, so accept and deliver never happen in the same cycle.
- Latency: out_valid rises exactly BEATS edges after the accepting edge. LANES=16 gives 1; LANES=4 gives 4; LANES=1 gives 16. Block throughput is one block per BEATS+2 cycles, minimum.
- Each lane computes its byte combinationally, with no ROM:
  - Forward: multiplicative inverse in GF(2^8) with polynomial 0x11B (inverse of 0x00 is 0x00), then the affine transform with constant 0x63.
  - Inverse: inverse affine transform (constant 0x05), then GF(2^8) inverse.
- All lanes share the mode captured at accept. Changing in_inv while BUSY or DONE has no effect.
- Bytes not yet written in the current block hold stale data. out_state must only be consumed while out_valid = 1.
- in_state and in_inv are ignored whenever in_ready = 0.
- out_ready is ignored outside DONE.
- If reset asserts mid-BUSY or in DONE, the block is abandoned: outputs go to their reset values immediately, and no partial result is presented.
- After reset deasserts, the first accept can occur at the first rising edge.
- Backpressure: DONE is held for any number of cycles, and out_state must not change while held.

Test Plan:
1. Reset, then LANES=4, forward, in_state bytes 0..15 = 19 3d e3 be a0 f4 e2 2b 9a c6 8d 2a e9 f8 48 08 -> out_valid 4 edges after accept; bytes = d4 27 11 ae e0 bf 98 f1 b8 b4 5d e5 1e 41 52 30.
2. Inverse mode with the scenario 1 output as input -> original 19 3d ... 08 returned. Boundary bytes: InvS(63)=00, S(00)=63, S(ff)=16, InvS(16)=ff.
3. Repeat scenario 1 with LANES = 1, 2, 8 and 16 -> same result; latency 16, 8, 2 and 1 edges respectively; busy high from the accepting edge until the handshake completes.
4. Hold out_ready=0 for 10 cycles in DONE while toggling in_valid and in_state -> out_state is stable, in_ready=0, no second block is accepted. Raise out_ready -> IDLE on the next edge, in_ready=1.
5. Assert reset asynchronously at beat 2 of a LANES=4 block -> out_valid=0, in_ready=1, out_state=0 immediately. The next block (all bytes 0x53, forward) gives all bytes 0xed.
6. Back-to-back: in_valid held high with alternating forward/inverse blocks and out_ready=1 -> each result matches its captured mode; a new accept occurs exactly one cycle after each DONE handshake.
